// File: rtl/rv_pkg.sv
// Shared fetch-side definitions: instruction field positions, reset vector default,
// fetch FSM states and the fetch-queue entry layout.
package rv_pkg;

    localparam int OPCODE_LSB = 0;
    localparam int OPCODE_MSB = 6;
    localparam int FUNCT3_LSB = 12;
    localparam int FUNCT3_MSB = 14;
    localparam int FUNCT7_LSB = 25;
    localparam int FUNCT7_MSB = 31;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] PC_STEP          = 32'd4;

    typedef enum logic {
        FETCH = 1'b0,
        FLUSH = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } fetch_entry_t;

    localparam int ENTRY_W = $bits(fetch_entry_t);

    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_fifo.sv
// Two-entry in-order queue between instruction memory responses and decode.
// Clear wins over push/pop; a push into a full queue is only taken alongside a pop.
module if_fifo
    import rv_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               push,
    input  logic               pop,
    input  logic [ENTRY_W-1:0] push_data,
    output logic [ENTRY_W-1:0] head_data,
    output logic               full,
    output logic               empty,
    output logic [1:0]         count
);

    logic [ENTRY_W-1:0] mem [2];
    logic               wr_ptr;
    logic               rd_ptr;
    logic               do_push;
    logic               do_pop;

    assign empty     = (count == 2'd0);
    assign full      = (count == 2'd2);
    assign do_pop    = pop && !empty;
    assign do_push   = push && (!full || do_pop);
    assign head_data = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else if (clear) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) wr_ptr <= ~wr_ptr;
            if (do_pop)  rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

    // NOTE: storage is deliberately not reset; an entry is only ever read while count marks it valid.
    always_ff @(posedge clk) begin
        if (do_push && !clear) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: issues word fetches under a two-credit limit, queues
// in-order responses for decode, and flushes stale responses after a redirect.
module instr_fetch_unit
    import rv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
)
(
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic [6:0]  if_opcode,
    output logic [2:0]  if_funct3,
    output logic [6:0]  if_funct7
);

    fetch_state_t state;
    logic         run;
    logic [31:0]  fetch_pc;
    logic [1:0]   outstanding;
    logic [1:0]   outstanding_next;
    logic [1:0]   drop_cnt;
    logic [1:0]   drop_next;

    logic         credit_ok;
    logic         accept;
    logic         resp_live;
    logic         push;
    logic         pop;

    fetch_entry_t push_entry;
    fetch_entry_t head_entry;
    logic         fifo_full;
    logic         fifo_empty;
    logic [1:0]   fifo_count;

    // Requests in flight plus queued words may never exceed the two queue slots.
    assign credit_ok = !fifo_full && (({1'b0, outstanding} + {1'b0, fifo_count}) < 3'd2);
    assign imem_req  = run && (state == FETCH) && credit_ok;
    assign imem_addr = fetch_pc;
    assign accept    = imem_req && imem_ready;

    assign resp_live        = imem_rvalid && (outstanding != 2'd0);
    assign outstanding_next = outstanding + {1'b0, accept} - {1'b0, resp_live};
    assign drop_next        = drop_cnt - {1'b0, imem_rvalid && (drop_cnt != 2'd0)};

    // In FETCH every outstanding request is sequential, so the oldest one sits
    // 4*outstanding bytes behind the next fetch address.
    assign push_entry.instr = imem_rdata;
    assign push_entry.pc    = fetch_pc - {28'd0, outstanding, 2'b00};
    assign push             = resp_live && (state == FETCH) && !redirect_valid;
    assign pop              = if_valid && if_ready;

    if_fifo u_fifo (
        .clk       (clk),
        .rst       (rst),
        .clear     (redirect_valid),
        .push      (push),
        .pop       (pop),
        .push_data (push_entry),
        .head_data (head_entry),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign if_valid  = !fifo_empty && (state == FETCH);
    assign if_instr  = if_valid ? head_entry.instr : 32'd0;
    assign if_pc     = if_valid ? head_entry.pc    : 32'd0;
    assign if_opcode = if_instr[OPCODE_MSB:OPCODE_LSB];
    assign if_funct3 = if_instr[FUNCT3_MSB:FUNCT3_LSB];
    assign if_funct7 = if_instr[FUNCT7_MSB:FUNCT7_LSB];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= FETCH;
            run         <= 1'b0;
            fetch_pc    <= RESET_PC;
            outstanding <= 2'd0;
            drop_cnt    <= 2'd0;
        end else begin
            run         <= 1'b1;
            outstanding <= outstanding_next;

            if (redirect_valid)
                fetch_pc <= align_word(redirect_pc);
            else if (accept)
                fetch_pc <= fetch_pc + PC_STEP;

            case (state)
                FETCH: begin
                    if (redirect_valid) begin
                        drop_cnt <= outstanding_next;
                        state    <= (outstanding_next != 2'd0) ? FLUSH : FETCH;
                    end
                end
                FLUSH: begin
                    drop_cnt <= drop_next;
                    if (drop_next == 2'd0) state <= FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios plus randomized traffic
// checked against a sequential-program-order model with an in-order memory model.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'd0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic        if_valid;
    logic        if_ready = 1'b0;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [6:0]  if_opcode;
    logic [2:0]  if_funct3;
    logic [6:0]  if_funct7;

    logic        w_imem_req;
    logic [31:0] w_imem_addr;
    logic        w_if_valid;
    logic [31:0] w_if_instr;
    logic [31:0] w_if_pc;
    logic [6:0]  w_if_opcode;
    logic [2:0]  w_if_funct3;
    logic [6:0]  w_if_funct7;

    always #5 clk = ~clk;

    instr_fetch_unit dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr), .if_pc(if_pc),
        .if_opcode(if_opcode), .if_funct3(if_funct3), .if_funct7(if_funct7)
    );

    instr_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk(clk), .rst(rst),
        .imem_req(w_imem_req), .imem_addr(w_imem_addr), .imem_ready(1'b1),
        .imem_rvalid(1'b0), .imem_rdata(32'd0),
        .redirect_valid(1'b0), .redirect_pc(32'd0),
        .if_valid(w_if_valid), .if_ready(1'b0), .if_instr(w_if_instr), .if_pc(w_if_pc),
        .if_opcode(w_if_opcode), .if_funct3(w_if_funct3), .if_funct7(w_if_funct7)
    );

    typedef struct {
        logic [31:0] addr;
        int          due;
    } resp_t;

    resp_t       resp_q[$];
    int          cyc;
    int          last_due;
    int          lat_lo;
    int          lat_hi;
    int          delivered;
    logic [31:0] exp_fetch;
    logic [31:0] exp_pc;
    int          req_cyc[logic [31:0]];
    int          pop_cyc[logic [31:0]];
    int          total = 0;
    int          bad = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return a & 32'hFFFF_FFFC;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic apply_reset();
        rst            = 1'b1;
        imem_ready     = 1'b0;
        imem_rvalid    = 1'b0;
        if_ready       = 1'b0;
        redirect_valid = 1'b0;
        resp_q.delete();
        req_cyc.delete();
        pop_cyc.delete();
        repeat (2) @(posedge clk);
        #1;
        check("rst_imem_req", 32'(imem_req), 32'd0);
        check("rst_if_valid", 32'(if_valid), 32'd0);
        check("rst_if_pc", if_pc, 32'd0);
        @(negedge clk);
        rst       = 1'b0;
        cyc       = 0;
        last_due  = -1;
        delivered = 0;
        exp_fetch = 32'h0;
        exp_pc    = 32'h0;
        #1;
        check("rel_imem_req", 32'(imem_req), 32'd0);
    endtask

    // One clock of traffic: drive inputs at the falling edge, score what the DUT
    // presented during this cycle, then return just after the rising edge.
    task automatic cycle(input logic rdy, input logic irdy, input logic redir, input logic [31:0] rpc);
        logic        s_req;
        logic        s_valid;
        logic [31:0] s_addr;
        logic [31:0] s_pc;
        logic [31:0] s_instr;
        logic [16:0] s_fields;
        logic [31:0] w;
        int          due;
        @(negedge clk);
        s_req    = imem_req;
        s_addr   = imem_addr;
        s_valid  = if_valid;
        s_pc     = if_pc;
        s_instr  = if_instr;
        s_fields = {if_funct7, if_funct3, if_opcode};
        if (resp_q.size() > 0 && resp_q[0].due <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(resp_q[0].addr);
            void'(resp_q.pop_front());
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = $urandom;
        end
        imem_ready     = rdy;
        if_ready       = irdy;
        redirect_valid = redir;
        redirect_pc    = rpc;
        if (s_req && rdy) begin
            check("req_addr", s_addr, exp_fetch);
            due = cyc + $urandom_range(lat_lo, lat_hi);
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            resp_q.push_back('{addr: s_addr, due: due});
            req_cyc[s_addr] = cyc;
            exp_fetch = exp_fetch + 32'd4;
        end
        if (s_valid && irdy) begin
            w = mem_word(exp_pc);
            check("if_pc", s_pc, exp_pc);
            check("if_instr", s_instr, w);
            check("if_fields", 32'(s_fields), 32'({w[31:25], w[14:12], w[6:0]}));
            pop_cyc[s_pc] = cyc;
            exp_pc = exp_pc + 32'd4;
            delivered++;
        end
        if (redir) begin
            exp_fetch = word_of(rpc);
            exp_pc    = word_of(rpc);
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        lat_lo = 1;
        lat_hi = 1;

        // Streaming with single-cycle memory; also the wrapping reset vector instance.
        apply_reset();
        @(posedge clk);
        #1;
        check("first_req", 32'(imem_req), 32'd1);
        check("first_addr", imem_addr, 32'h0);
        check("wrap_req0", 32'(w_imem_req), 32'd1);
        check("wrap_addr0", w_imem_addr, 32'hFFFF_FFFC);
        cycle(1'b1, 1'b1, 1'b0, 32'd0);
        check("wrap_req1", 32'(w_imem_req), 32'd1);
        check("wrap_addr1", w_imem_addr, 32'h0000_0000);
        for (int i = 0; i < 8; i++) cycle(1'b1, 1'b1, 1'b0, 32'd0);
        check("seq_req_gap", 32'(req_cyc[32'h4] - req_cyc[32'h0]), 32'd1);
        check("lat_pc0", 32'(pop_cyc[32'h0] - req_cyc[32'h0]), 32'd2);
        check("lat_pc4", 32'(pop_cyc[32'h4] - req_cyc[32'h4]), 32'd2);
        check("lat_pc8", 32'(pop_cyc[32'h8] - req_cyc[32'h8]), 32'd2);

        // Decode stalled: two words queued, fetch throttled, then in-order drain.
        apply_reset();
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 1'b0, 32'd0);
        check("stall_req", 32'(imem_req), 32'd0);
        check("stall_valid", 32'(if_valid), 32'd1);
        check("stall_head", if_pc, 32'h0);
        for (int i = 0; i < 6; i++) cycle(1'b1, 1'b1, 1'b0, 32'd0);
        check("stall_drained", 32'(delivered >= 2), 32'd1);

        // Redirect with two requests in flight: both responses dropped.
        lat_lo = 3;
        lat_hi = 3;
        apply_reset();
        cycle(1'b1, 1'b1, 1'b0, 32'd0);
        cycle(1'b1, 1'b1, 1'b0, 32'd0);
        cycle(1'b1, 1'b1, 1'b1, 32'h100);
        check("flush_req_a", 32'(imem_req), 32'd0);
        cycle(1'b1, 1'b1, 1'b0, 32'd0);
        check("flush_req_b", 32'(imem_req), 32'd0);
        cycle(1'b1, 1'b1, 1'b0, 32'd0);
        check("flush_resume", 32'(imem_req), 32'd1);
        check("flush_addr", imem_addr, 32'h100);
        for (int i = 0; i < 10; i++) cycle(1'b1, 1'b1, 1'b0, 32'd0);
        check("flush_no_old", 32'(pop_cyc.exists(32'h0)), 32'd0);
        check("flush_new_pc", 32'(pop_cyc.exists(32'h100)), 32'd1);

        // Redirect coinciding with a response: that response is discarded.
        lat_lo = 1;
        lat_hi = 1;
        apply_reset();
        cycle(1'b1, 1'b1, 1'b0, 32'd0);
        cycle(1'b1, 1'b1, 1'b1, 32'h203);
        check("same_cyc_valid", 32'(if_valid), 32'd0);
        cycle(1'b1, 1'b1, 1'b0, 32'd0);
        check("same_cyc_addr", imem_addr, 32'h200);
        for (int i = 0; i < 8; i++) cycle(1'b1, 1'b1, 1'b0, 32'd0);
        check("same_cyc_no_old", 32'(pop_cyc.exists(32'h0)), 32'd0);
        check("same_cyc_new", 32'(pop_cyc.exists(32'h200)), 32'd1);

        // Asynchronous reset with the queue full.
        apply_reset();
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 1'b0, 32'd0);
        check("full_valid", 32'(if_valid), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("arst_req", 32'(imem_req), 32'd0);
        check("arst_valid", 32'(if_valid), 32'd0);
        check("arst_instr", if_instr, 32'd0);
        check("arst_pc", if_pc, 32'd0);
        check("arst_fields", 32'({if_funct7, if_funct3, if_opcode}), 32'd0);
        apply_reset();
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, 1'b0, 32'd0);
        check("arst_first_pc", 32'(pop_cyc.exists(32'h0)), 32'd1);

        // Randomized traffic: variable latency, backpressure and redirects.
        lat_lo = 1;
        lat_hi = 4;
        apply_reset();
        for (int i = 0; i < 3000; i++) begin
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
                  $urandom_range(0, 24) == 0, $urandom);
        end
        for (int i = 0; i < 20; i++) cycle(1'b1, 1'b1, 1'b0, 32'd0);
        check("random_progress", 32'(delivered > 200), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
